// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e     : fetch FSM encodings (IDLE, FETCH, HOLD, FAULT)
//   NOP_INSTR         : addi x0,x0,0, the instruction register value after reset
//   DEFAULT_RESET_PC  : default program counter loaded on reset
//   OPC_*             : base opcodes shared with the main decoder
//   is_aligned()      : word-alignment test for redirect targets
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bundle.
//   imem_request  : fetch request (fetch unit -> memory)
//   imem_address  : fetch address, stable while imem_request=1
//   imem_ready    : memory returns imem_data this cycle
//   imem_data     : instruction word from memory
// master = fetch unit, slave = instruction memory.
interface fetch_unit_if;
  logic        imem_request;
  logic [31:0] imem_address;
  logic        imem_ready;
  logic [31:0] imem_data;

  modport master (
    output imem_request,
    output imem_address,
    input  imem_ready,
    input  imem_data
  );

  modport slave (
    input  imem_request,
    input  imem_address,
    output imem_ready,
    output imem_data
  );
endinterface

// File: rtl/fetch_unit_pc_register.sv
// Program counter register with its sequential-address adder.
//   clock     : system clock
//   reset     : synchronous active-high reset, loads RESET_PC
//   load      : capture pc_next on the next rising edge
//   pc_next   : next program counter value
//   pc        : current program counter
//   pc_plus4  : pc + 4, wrapping modulo 2^32
module fetch_unit_pc_register
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= pc_next;
    end
  end

  // 32-bit add; the carry out of bit 31 is dropped so 0xFFFF_FFFC wraps to 0.
  assign pc_plus4 = pc + 32'd4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one request at a time to a
// variable-latency instruction memory, latches the returned word and offers
// it to decode with a valid/ready handshake.
//   clock, reset        : system clock, synchronous active-high reset
//   imem                : instruction memory bundle (master side)
//   pc_src              : on consume, 1 = redirect to target_address
//   target_address      : branch/jump target from the datapath
//   instruction_ready   : decode consumes the current instruction
//   instruction         : latched instruction word
//   instruction_valid   : instruction register holds the word for pc
//   pc, pc_plus4        : current pc and its sequential successor
//   misaligned_fault    : sticky, a redirect target was not word aligned
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | one cycle after reset, nothing outstanding
// ST_FETCH | request to memory at pc, waiting for imem_ready
// ST_HOLD  | instruction valid, waiting for decode to consume it
// ST_FAULT | misaligned redirect seen, frozen until reset
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clock,
  input  logic                reset,
  fetch_unit_if.master        imem,
  input  logic                pc_src,
  input  logic [31:0]         target_address,
  input  logic                instruction_ready,
  output logic [31:0]         instruction,
  output logic                instruction_valid,
  output logic [31:0]         pc,
  output logic [31:0]         pc_plus4,
  output logic                misaligned_fault
);

  fetch_state_e state;

  logic        consume;
  logic        redirect_ok;
  logic        pc_load;
  logic [31:0] pc_next;

  assign consume     = (state == ST_HOLD) && instruction_ready;
  assign redirect_ok = !pc_src || is_aligned(target_address);
  // A misaligned redirect leaves pc pointing at the offending instruction.
  assign pc_load     = consume && redirect_ok;
  assign pc_next     = pc_src ? target_address : pc_plus4;

  fetch_unit_pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clock    (clock),
    .reset    (reset),
    .load     (pc_load),
    .pc_next  (pc_next),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= ST_IDLE;
      instruction       <= NOP_INSTR;
      instruction_valid <= 1'b0;
      misaligned_fault  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem.imem_ready) begin
            instruction       <= imem.imem_data;
            instruction_valid <= 1'b1;
            state             <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (instruction_ready) begin
            instruction_valid <= 1'b0;
            if (redirect_ok) begin
              state <= ST_FETCH;
            end else begin
              misaligned_fault <= 1'b1;
              state            <= ST_FAULT;
            end
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_FAULT;
        end
      endcase
    end
  end

  // Request is a pure decode of the state so it drops the cycle after reset
  // is sampled, abandoning any outstanding fetch.
  assign imem.imem_request = (state == ST_FETCH);
  assign imem.imem_address = pc;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle RISC-V core, directly upstream of the main decoder. It owns the program counter and issues one request at a time to a variable-latency instruction memory. It latches the returned word into an instruction register and presents it to the decode/execute path with a valid/ready handshake. On consume, it takes the next PC from the datapath: either sequential, or the branch/jump target.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- pc_src  input  1  1 = take target_address as next PC (branch taken or jal); sampled only on consume
- target_address  input  32  branch/jump target computed by datapath
- instruction_ready  input  1  core consumes the current instruction this cycle
- imem_ready  input  1  memory returns imem_data this cycle; meaningful only while imem_request=1
- imem_data  input  32  instruction word from memory
- imem_request  output  1  fetch request to memory
- imem_address  output  32  fetch address; equals pc, stable while imem_request=1
- instruction  output  32  latched instruction word; instruction[6:0] is the opcode feeding the main decoder
- instruction_valid  output  1  instruction register holds a word for the current pc
- pc  output  32  address of the current instruction
- pc_plus4  output  32  pc + 4 modulo 2^32, used for the jal link value
- misaligned_fault  output  1  sticky; set when a redirect target has address[1:0] != 0

## Operation
- States:
  - IDLE: one cycle after reset.
  - FETCH: imem_request=1, waiting for imem_ready.
  - HOLD: instruction_valid=1, waiting for instruction_ready.
  - FAULT: terminal until reset.
- Transitions:
  - IDLE -> FETCH unconditionally.
  - FETCH stays in FETCH while imem_ready=0. On imem_ready=1: instruction <= imem_data, go to HOLD.
  - HOLD stays in HOLD while instruction_ready=0; instruction and pc are held.
- Consume (HOLD and instruction_ready=1):
  - pc_src=0: pc <= pc+4, go to FETCH.
  - pc_src=1 and target_address[1:0]==0: pc <= target_address, go to FETCH.
  - pc_src=1 and target_address[1:0]!=0: pc unchanged, misaligned_fault <= 1, go to FAULT.
- FAULT: imem_request=0, instruction_valid=0. Only reset exits this state.
- pc_src and target_address are ignored outside a consume cycle.
- Arithmetic: pc+4 is 32-bit with wrap. 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- Reset values:
  - State: IDLE.
  - pc = RESET_PC.
  - pc_plus4 = RESET_PC+4.
  - instruction = 32'h0000_0013 (nop, addi x0,x0,0).
  - instruction_valid = 0.
  - imem_request = 0.
  - misaligned_fault = 0.
- Reset mid-fetch: the outstanding request is abandoned and imem_request drops in the cycle after reset is sampled. A late imem_ready is ignored because imem_request=0. The first post-reset request uses RESET_PC.
- Reset has priority over every other input in the same cycle.
- RESET_PC with nonzero [1:0] is a configuration error, not checked in RTL.

## Timing
- All outputs are registered except:
  - imem_address, which equals pc.
  - pc_plus4, which is combinational from pc.
  - imem_request, which decodes state==FETCH.
- Reset deasserted at edge 0: IDLE during cycle 0, FETCH with imem_request=1 in cycle 1.
- With imem_ready=1 in cycle 1, instruction_valid=1 from cycle 2.
- Memory latency L cycles (imem_ready asserted L cycles after request rises, L>=0): instruction_valid rises L+1 cycles after imem_request rises.
- Zero-wait memory with instruction_ready tied high gives 1 instruction per 2 cycles.
- The new pc is visible in the cycle after consume, together with imem_request=1 and instruction_valid=0.
- Memory contract: imem_address and imem_request stay stable until imem_ready. The unit never has more than one request outstanding.

## Structure
- Shared include cpu_defines.vh holds:
  - fetch state encodings (2 bits: IDLE, FETCH, HOLD, FAULT);
  - the NOP constant 32'h0000_0013;
  - the default RESET_PC;
  - opcode constants shared with the main decoder.
- One sub-module, pc_register: 32-bit register with synchronous active-high reset to RESET_PC, load enable, and data input. It also provides the pc+4 adder output.
- The FSM and instruction register live in fetch_unit.

## Test plan
- Reset then zero-wait memory, instruction_ready=1, pc_src=0 → imem_address sequence 0,4,8,C on alternate cycles; instruction_valid pulses in the cycles between fetches; instruction matches imem_data.
- Memory latency 3, instruction_ready=0 for 5 cycles after valid → request held 4 cycles at the same address; instruction and pc stable throughout HOLD; no second request.
- Consume with pc_src=1, target_address=32'h0000_0100 → next imem_address=0x100, pc_plus4=0x104.
- Consume with pc_src=1, target_address=32'h0000_0102 → misaligned_fault=1, imem_request stays 0, pc unchanged; reset clears the fault and restarts at RESET_PC.
- RESET_PC=32'hFFFF_FFFC, one consume with pc_src=0 → pc=0x0000_0000, no fault.
- Reset asserted in FETCH at cycle 2 of a 4-cycle latency, memory then asserts imem_ready → response ignored, instruction_valid=0; new request to RESET_PC in the second cycle after reset is released.
